// File: rtl/issue_queue_rr_pkg.sv
// -----------------------------------------------------------------------------
// tomasula_types
// Shared types for the issue queue and its neighbours: the decoded control
// word that flows from the instruction register to the reservation stations,
// the operation class enum, and the idle word shown when nothing is queued.
// -----------------------------------------------------------------------------
package tomasula_types;

  // BRANCH is encoded as zero so that the idle word is the all-zero pattern.
  typedef enum logic [2:0] {
    BRANCH = 3'd0,
    ALU    = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    MUL    = 3'd4
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } ctl_word;

  localparam ctl_word IQ_IDLE_WORD = '{op: BRANCH, rd: '0, rs1: '0, rs2: '0, imm: '0};

endpackage

// File: rtl/issue_queue_rr_if.sv
// -----------------------------------------------------------------------------
// issue_queue_rr_if
// Bundles the enqueue handshake, flush, downstream free/full flags, dispatch
// strobes and status outputs of the issue queue.
//   master : the surrounding pipeline (IR, ROB, reservation stations)
//   slave  : the issue queue itself
// Signals:
//   enq_valid/enq_word/enq_ack  enqueue handshake from the IR
//   flush                       mispredict recovery, empties the queue
//   rob_full, rs_empty, resbr_empty  downstream availability
//   rs_load, resbr_load, rob_load    dispatch strobes
//   ctl_o, count, full, empty        head word and occupancy
// -----------------------------------------------------------------------------
interface issue_queue_rr_if #(
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  import tomasula_types::*;

  logic              enq_valid;
  ctl_word           enq_word;
  logic              enq_ack;
  logic              flush;
  logic              rob_full;
  logic [NUM_RS-1:0] rs_empty;
  logic              resbr_empty;
  logic [NUM_RS-1:0] rs_load;
  logic              resbr_load;
  logic              rob_load;
  ctl_word           ctl_o;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output enq_valid, enq_word, flush, rob_full, rs_empty, resbr_empty,
    input  enq_ack, rs_load, resbr_load, rob_load, ctl_o, count, full, empty
  );

  modport slave (
    input  enq_valid, enq_word, flush, rob_full, rs_empty, resbr_empty,
    output enq_ack, rs_load, resbr_load, rob_load, ctl_o, count, full, empty
  );

endinterface

// File: rtl/issue_queue_rr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: scans req upward starting at ptr,
// wrapping modulo N, and grants the first set bit.
// Ports:
//   req         request vector (one bit per requester)
//   ptr         index where the search starts
//   grant       one-hot grant, all zero when nothing requests
//   grant_idx   index of the granted bit
//   grant_valid at least one request was present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  int          pos;
  logic [PW-1:0] idx;

  // Walk the N candidate positions in priority order; once one is granted
  // the rest of the scan is ignored.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = 0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr) + i) % N;
      idx = PW'(pos);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_rr.sv
// -----------------------------------------------------------------------------
// issue_queue_rr
// In-order instruction issue queue between the instruction register and the
// Tomasulo reservation stations / ROB. Words are buffered in a DEPTH-entry
// circular buffer; the head entry dispatches to the branch RS if it is a
// branch, otherwise to a general RS chosen round-robin among the free ones.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         issue_queue_rr_if.slave: enqueue handshake, flush,
//               downstream availability, dispatch strobes, head word,
//               occupancy (count/full/empty)
// Optional build macro ISSUE_Q_PERF_CNT_EN adds two saturating 32-bit stall
// counters as extra ports:
//   stall_rob_cnt  cycles with a queued head blocked by a full ROB
//   stall_rs_cnt   cycles with a queued head blocked by no free station
// -----------------------------------------------------------------------------
module issue_queue_rr
  import tomasula_types::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  issue_queue_rr_if.slave bus
`ifdef ISSUE_Q_PERF_CNT_EN
  ,
  output logic [31:0] stall_rob_cnt,
  output logic [31:0] stall_rs_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  ctl_word          buffer [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [RR_W-1:0]  rr;

  logic             full;
  logic             empty;
  logic             enq_ack;
  ctl_word          head_word;
  logic             head_is_branch;
  logic             can_issue;
  logic             dispatch;

  logic [NUM_RS-1:0] grant;
  logic [RR_W-1:0]   grant_idx;
  logic              grant_valid;
  logic [RR_W-1:0]   rr_next;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // rst_n is folded in so the handshake reads 0 while reset is held, even
  // if the IR keeps enq_valid high.
  assign enq_ack = bus.enq_valid & ~full & ~bus.flush & rst_n;

  assign head_word      = buffer[head];
  assign head_is_branch = (head_word.op == BRANCH);

  // Everything downstream of the head hinges on this: something queued,
  // a ROB slot available, and no recovery in progress.
  assign can_issue = ~empty & ~bus.rob_full & ~bus.flush;

  rr_arbiter #(
    .N  (NUM_RS),
    .PW (RR_W)
  ) u_rr_arbiter (
    .req         (bus.rs_empty),
    .ptr         (rr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The pointer moves one past the station just granted so the next search
  // starts with its neighbour.
  assign rr_next = (grant_idx == RR_W'(NUM_RS - 1)) ? '0 : grant_idx + RR_W'(1);

  // Dispatch decision and strobes. A stalled branch blocks everything
  // behind it because only the head is ever considered.
  always_comb begin
    dispatch       = 1'b0;
    bus.rs_load    = '0;
    bus.resbr_load = 1'b0;
    if (can_issue) begin
      if (head_is_branch) begin
        dispatch       = bus.resbr_empty;
        bus.resbr_load = bus.resbr_empty;
      end else begin
        dispatch    = grant_valid;
        bus.rs_load = grant;
      end
    end
  end

  assign bus.rob_load = dispatch;
  assign bus.enq_ack  = enq_ack;
  assign bus.ctl_o    = empty ? IQ_IDLE_WORD : head_word;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;

  // Storage array carries no reset; validity is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (enq_ack) begin
      buffer[tail] <= bus.enq_word;
    end
  end

  // Pointers and occupancy. Flush wins over both enqueue and dispatch; the
  // pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_ack) begin
        tail <= tail + 1'b1;
      end
      if (dispatch) begin
        head <= head + 1'b1;
      end
      unique case ({enq_ack, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Round-robin pointer only moves on a general-station dispatch; a flush
  // leaves it untouched so fairness survives mispredict recovery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (dispatch && !head_is_branch) begin
      rr <= rr_next;
    end
  end

`ifdef ISSUE_Q_PERF_CNT_EN
  // Stall accounting: a full ROB and a missing free station are counted
  // separately; both saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_cnt <= '0;
      stall_rs_cnt  <= '0;
    end else begin
      if (~empty && bus.rob_full && ~bus.flush && (stall_rob_cnt != '1)) begin
        stall_rob_cnt <= stall_rob_cnt + 1'b1;
      end
      if (can_issue && !dispatch && (stall_rs_cnt != '1)) begin
        stall_rs_cnt <= stall_rs_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_rr.sv
// -----------------------------------------------------------------------------
// tb_issue_queue_rr
// Directed bench for issue_queue_rr (DEPTH=8, NUM_RS=4). Inputs are changed
// 1 time unit after each rising edge and outputs are sampled 1 time unit
// later, well away from the next edge. Expected values are written out by
// hand for each step.
// -----------------------------------------------------------------------------
module tb_issue_queue_rr;
  import tomasula_types::*;

  localparam int DEPTH  = 8;
  localparam int NUM_RS = 4;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatch;

  issue_queue_rr_if #(.DEPTH(DEPTH), .NUM_RS(NUM_RS)) bus ();

  issue_queue_rr #(
    .DEPTH  (DEPTH),
    .NUM_RS (NUM_RS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Builds a recognisable control word from an id.
  function automatic ctl_word mk(input op_t op, input int id);
    ctl_word w;
    w.op  = op;
    w.rd  = 5'(id);
    w.rs1 = 5'(id + 1);
    w.rs2 = 5'(id + 2);
    w.imm = 16'(id * 3 + 7);
    return w;
  endfunction

  // Drives every input, then lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input ctl_word w, input logic fl,
                               input logic rf, input logic [3:0] rse, input logic rbe);
    bus.enq_valid   = v;
    bus.enq_word    = w;
    bus.flush       = fl;
    bus.rob_full    = rf;
    bus.rs_empty    = rse;
    bus.resbr_empty = rbe;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_load;
    n_compared = 0;
    n_mismatch = 0;

    // Reset state, with enq_valid held high to show enq_ack stays low.
    rst_n = 1'b0;
    applyStimulus(1'b1, mk(ALU, 1), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("rst_enq_ack", 64'(bus.enq_ack), 64'd0);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_empty", 64'(bus.empty), 64'd1);
    checkOutput("rst_full", 64'(bus.full), 64'd0);
    checkOutput("rst_rs_load", 64'(bus.rs_load), 64'd0);
    checkOutput("rst_rob_load", 64'(bus.rob_load), 64'd0);
    checkOutput("rst_resbr_load", 64'(bus.resbr_load), 64'd0);
    checkOutput("rst_ctl_o", 64'(bus.ctl_o), 64'(IQ_IDLE_WORD));
    tick();
    tick();
    rst_n = 1'b1;

    // Three ALU words back to back: round-robin 0001, 0010, 0100.
    $display("[TB] round-robin dispatch of three ALU words");
    applyStimulus(1'b1, mk(ALU, 1), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t1_ack0", 64'(bus.enq_ack), 64'd1);
    checkOutput("t1_noload_empty", 64'(bus.rob_load), 64'd0);
    tick();
    applyStimulus(1'b1, mk(ALU, 2), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t1_ctl_w1", 64'(bus.ctl_o), 64'(mk(ALU, 1)));
    checkOutput("t1_rs_load_a", 64'(bus.rs_load), 64'b0001);
    checkOutput("t1_rob_load_a", 64'(bus.rob_load), 64'd1);
    tick();
    applyStimulus(1'b1, mk(ALU, 3), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t1_count_steady", 64'(bus.count), 64'd1);
    checkOutput("t1_ctl_w2", 64'(bus.ctl_o), 64'(mk(ALU, 2)));
    checkOutput("t1_rs_load_b", 64'(bus.rs_load), 64'b0010);
    tick();
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t1_ctl_w3", 64'(bus.ctl_o), 64'(mk(ALU, 3)));
    checkOutput("t1_rs_load_c", 64'(bus.rs_load), 64'b0100);
    checkOutput("t1_rob_load_c", 64'(bus.rob_load), 64'd1);
    tick();
    checkOutput("t1_count_end", 64'(bus.count), 64'd0);
    checkOutput("t1_empty_end", 64'(bus.empty), 64'd1);

    // Fill all eight entries behind a full ROB; a ninth is refused.
    $display("[TB] fill to full, then drain with wrap");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, mk(LOAD, 10 + i), 1'b0, 1'b1, 4'b1111, 1'b1);
      checkOutput("t2_fill_ack", 64'(bus.enq_ack), 64'd1);
      checkOutput("t2_fill_rob_load", 64'(bus.rob_load), 64'd0);
      tick();
    end
    applyStimulus(1'b1, mk(ALU, 18), 1'b0, 1'b1, 4'b1111, 1'b1);
    checkOutput("t2_full", 64'(bus.full), 64'd1);
    checkOutput("t2_count8", 64'(bus.count), 64'd8);
    checkOutput("t2_ninth_ack", 64'(bus.enq_ack), 64'd0);
    tick();
    checkOutput("t2_count_hold", 64'(bus.count), 64'd8);
    // rr is 3 after the first test, so grants run 1000, 0001, 0010, ...
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
      exp_load = 4'b0001 << ((3 + i) % 4);
      checkOutput("t2_drain_ctl", 64'(bus.ctl_o), 64'(mk(LOAD, 10 + i)));
      checkOutput("t2_drain_rs_load", 64'(bus.rs_load), 64'(exp_load));
      checkOutput("t2_drain_rob_load", 64'(bus.rob_load), 64'd1);
      tick();
    end
    checkOutput("t2_drained", 64'(bus.empty), 64'd1);
    applyStimulus(1'b1, mk(STORE, 20), 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();
    applyStimulus(1'b1, mk(MUL, 21), 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t2_count2", 64'(bus.count), 64'd2);
    checkOutput("t2_ctl_w20", 64'(bus.ctl_o), 64'(mk(STORE, 20)));
    checkOutput("t2_rs_load_w20", 64'(bus.rs_load), 64'b1000);
    tick();
    checkOutput("t2_ctl_w21", 64'(bus.ctl_o), 64'(mk(MUL, 21)));
    checkOutput("t2_rs_load_w21", 64'(bus.rs_load), 64'b0001);
    tick();

    // Branch at head blocks the ALU word behind it until the branch RS frees.
    $display("[TB] branch stall and in-order release");
    applyStimulus(1'b1, mk(BRANCH, 30), 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();
    applyStimulus(1'b1, mk(ALU, 31), 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b0);
    checkOutput("t3_stall_rs_load", 64'(bus.rs_load), 64'd0);
    checkOutput("t3_stall_resbr", 64'(bus.resbr_load), 64'd0);
    checkOutput("t3_stall_rob", 64'(bus.rob_load), 64'd0);
    checkOutput("t3_stall_op", 64'(bus.ctl_o.op), 64'(BRANCH));
    checkOutput("t3_stall_ctl", 64'(bus.ctl_o), 64'(mk(BRANCH, 30)));
    tick();
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t3_stall_count", 64'(bus.count), 64'd2);
    checkOutput("t3_resbr_load", 64'(bus.resbr_load), 64'd1);
    checkOutput("t3_br_rob_load", 64'(bus.rob_load), 64'd1);
    checkOutput("t3_br_rs_load", 64'(bus.rs_load), 64'd0);
    tick();
    checkOutput("t3_alu_ctl", 64'(bus.ctl_o), 64'(mk(ALU, 31)));
    checkOutput("t3_alu_rs_load", 64'(bus.rs_load), 64'b0010);
    checkOutput("t3_alu_resbr", 64'(bus.resbr_load), 64'd0);
    tick();

    // rr is now 2; with only stations 0 and 3 free the search wraps.
    $display("[TB] round-robin wrap with sparse free stations");
    applyStimulus(1'b1, mk(ALU, 40), 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();
    applyStimulus(1'b1, mk(ALU, 41), 1'b0, 1'b1, 4'b1111, 1'b1);
    tick();
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1001, 1'b1);
    checkOutput("t5_rs_load_first", 64'(bus.rs_load), 64'b1000);
    tick();
    checkOutput("t5_ctl_w41", 64'(bus.ctl_o), 64'(mk(ALU, 41)));
    checkOutput("t5_rs_load_second", 64'(bus.rs_load), 64'b0001);
    tick();
    checkOutput("t5_empty", 64'(bus.empty), 64'd1);

    // Flush with five entries queued and an enqueue attempt in the same cycle.
    $display("[TB] flush with pending enqueue");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mk(ALU, 50 + i), 1'b0, 1'b1, 4'b1111, 1'b1);
      tick();
    end
    applyStimulus(1'b1, mk(ALU, 55), 1'b1, 1'b0, 4'b1111, 1'b1);
    checkOutput("t4_count5", 64'(bus.count), 64'd5);
    checkOutput("t4_flush_ack", 64'(bus.enq_ack), 64'd0);
    checkOutput("t4_flush_rs_load", 64'(bus.rs_load), 64'd0);
    checkOutput("t4_flush_rob_load", 64'(bus.rob_load), 64'd0);
    checkOutput("t4_flush_resbr", 64'(bus.resbr_load), 64'd0);
    tick();
    applyStimulus(1'b1, mk(ALU, 60), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t4_post_count", 64'(bus.count), 64'd0);
    checkOutput("t4_post_empty", 64'(bus.empty), 64'd1);
    checkOutput("t4_post_ctl_idle", 64'(bus.ctl_o), 64'(IQ_IDLE_WORD));
    checkOutput("t4_post_ack", 64'(bus.enq_ack), 64'd1);
    tick();
    // rr was 1 before the flush and must still be 1.
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t4_ctl_w60", 64'(bus.ctl_o), 64'(mk(ALU, 60)));
    checkOutput("t4_rr_kept", 64'(bus.rs_load), 64'b0010);
    tick();

    // Asynchronous reset in the middle of a cycle with four entries queued.
    $display("[TB] asynchronous reset mid-cycle");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mk(LOAD, 70 + i), 1'b0, 1'b1, 4'b1111, 1'b1);
      tick();
    end
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b1, 4'b1111, 1'b1);
    checkOutput("t6_count4", 64'(bus.count), 64'd4);
    #2;
    rst_n = 1'b0;
    applyStimulus(1'b1, mk(ALU, 75), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t6_rst_count", 64'(bus.count), 64'd0);
    checkOutput("t6_rst_empty", 64'(bus.empty), 64'd1);
    checkOutput("t6_rst_ctl", 64'(bus.ctl_o), 64'(IQ_IDLE_WORD));
    checkOutput("t6_rst_rs_load", 64'(bus.rs_load), 64'd0);
    checkOutput("t6_rst_rob_load", 64'(bus.rob_load), 64'd0);
    checkOutput("t6_rst_ack", 64'(bus.enq_ack), 64'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t6_after_count", 64'(bus.count), 64'd0);
    checkOutput("t6_after_empty", 64'(bus.empty), 64'd1);
    applyStimulus(1'b1, mk(ALU, 80), 1'b0, 1'b0, 4'b1111, 1'b1);
    tick();
    // rr was cleared by reset, so the search starts at station 0 again.
    applyStimulus(1'b0, mk(ALU, 0), 1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("t6_ctl_w80", 64'(bus.ctl_o), 64'(mk(ALU, 80)));
    checkOutput("t6_rr_reset", 64'(bus.rs_load), 64'b0001);
    tick();
    checkOutput("t6_final_empty", 64'(bus.empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/issue_queue_rr.md
Name: issue_queue_rr

Overview:
Parametrised successor to the single-entry-routing instruction queue, sitting between the instruction register and the Tomasulo reservation stations and ROB. It buffers decoded control words in an internal circular buffer of DEPTH entries and dispatches the head entry in order. Branches go to the branch RS. All other ops go to one of NUM_RS general reservation stations, chosen by a round-robin arbiter rather than fixed priority. It adds a synchronous flush for misprediction recovery and exposes its occupancy.

Parameters:
DEPTH, 8, number of queue entries; power of two, 2..64
NUM_RS, 4, number of general (non-branch) reservation stations; 1..16
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
enq_valid  in  1  IR presents a control word
enq_word  in  ctl_word  control word to enqueue
enq_ack  out  1  word accepted this cycle
flush  in  1  discard all queued entries (mispredict recovery)
rob_full  in  1  ROB cannot accept an entry
rs_empty  in  NUM_RS  per-station free flag
resbr_empty  in  1  branch RS free
rs_load  out  NUM_RS  one-hot load strobe to general RS
resbr_load  out  1  load strobe to branch RS
rob_load  out  1  ROB allocate strobe
ctl_o  out  ctl_word  head entry, or idle word
count  out  CNT_W  valid entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - head, tail, count and the rr pointer are cleared to 0.
  - All load strobes and enq_ack are 0; empty=1, full=0.
  - ctl_o is the idle word: op=BRANCH, all other fields 0.
- Storage:
  - Circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping naturally.
  - count is tracked separately so full and empty are unambiguous.
- Enqueue:
  - enq_ack = enq_valid & ~full & ~flush; this is combinational.
  - On an ack, the word is written at tail and tail increments.
  - No acceptance when full, even if a dequeue occurs in the same cycle.
- Latency and ctl_o:
  - Minimum enqueue-to-dispatch latency is 1 cycle; there is no pass-through when the queue is empty.
  - ctl_o = buffer[head] when ~empty, otherwise the idle word.
- Dispatch (combinational, committed at the clock edge):
  - Precondition: ~empty & ~rob_full & ~flush.
  - Branch at head: dispatch iff resbr_empty; resbr_load=1.
  - Non-branch at head: dispatch iff |rs_empty. rs_load is one-hot on the first set bit of rs_empty, searching upward from rr and wrapping modulo NUM_RS. After the dispatch, rr becomes chosen+1 mod NUM_RS.
  - rob_load = dispatch. head increments on dispatch.
  - When dispatch is not possible, all strobes are 0 and the head stays.
- Simultaneous events:
  - Enqueue and dispatch in the same cycle: count is unchanged.
  - flush has priority over both. In a flush cycle there is no enq_ack and no strobes; the following edge sets head=tail=count=0.
  - rr is unaffected by flush.
- Stall cases: a branch at head with resbr_empty=0 blocks younger non-branch entries. Dispatch is strictly in order.
- Reset mid-operation discards all entries immediately; outputs take their reset values asynchronously.

Optional Feature:
ISSUE_Q_PERF_CNT_EN
- Defined: adds output ports stall_rob_cnt and stall_rs_cnt, each 32 bits, saturating.
  - stall_rob_cnt increments each cycle with ~empty & rob_full & ~flush.
  - stall_rs_cnt increments each cycle with ~empty & ~rob_full & ~flush where the head cannot dispatch for lack of a free RS.
  - Both counters are cleared by reset only.
- Undefined: the ports and logic are absent; functional behaviour is identical.

Decomposition:
- tomasula_types package holds ctl_word, the op enum (BRANCH etc.) and the idle-word constant IQ_IDLE_WORD.
- One sub-module, rr_arbiter, parametrised by N. It takes req[N] and ptr and produces a one-hot grant and its index; it is purely combinational.
- The pointer, buffer and count registers live in issue_queue_rr.

Test Plan:
1. Reset, then enqueue 3 ALU words with all rs_empty=1 and rob_full=0 -> rs_load sequence 0001, 0010, 0100 on consecutive cycles; rob_load=1 each cycle; count returns to 0.
2. Fill with DEPTH=8 words while rob_full=1 -> full=1, count=8; a 9th enq_valid gets enq_ack=0. Release rob_full -> 8 dispatches in order and tail wraps. Then enqueue 2 more -> correct words at ctl_o.
3. Branch at head with resbr_empty=0 and an ALU word behind it -> no strobes and ctl_o.op=BRANCH. Set resbr_empty=1 -> resbr_load=1, then the next cycle rs_load for the ALU word.
4. count=5 and enq_valid=1 with flush=1 -> enq_ack=0, all loads 0, and next cycle count=0, empty=1, ctl_o = idle word.
5. rr=2 with rs_empty=1001 (NUM_RS=4) -> rs_load=1000, then rr=0; next dispatch with rs_empty=1001 -> rs_load=0001.
6. Deassert rst_n mid-cycle while count=4 -> outputs go to reset values before the next edge; after release, queue is empty.
